spi_flash_reader: RTL
=====================

Name: spi_flash_reader

Overview:
- Single-bit SPI flash read initiator, mode 0. It is the controller-side counterpart to the spiflash responder model used in the user-project benches.
- Accepts a 24-bit byte address and issues READ (0x03), the address MSB-first, then clocks in 4 data bytes.
- Returns one 32-bit little-endian word over a valid/ready response handshake.
- Sits between a bus bridge and the mprj_io flash pins: csb, clk, io0 as MOSI, io1 as MISO.

Parameters:
- CLK_DIV, 2, system clocks per SPI clock half-period; legal range 1..255.
- CSB_HIGH, 4, minimum system clocks flash_csb stays high between transactions; legal range 1..255.

Ports:
- clock  input  1  system clock; all state changes on its rising edge
- resetb  input  1  asynchronous active-low reset
- req_valid  input  1  read request
- req_ready  output  1  request accepted when req_valid && req_ready
- req_addr  input  24  flash byte address; sampled at acceptance
- rsp_valid  output  1  read data available
- rsp_ready  input  1  consumer takes data
- rsp_data  output  32  first received byte in [7:0], fourth in [31:24]
- busy  output  1  high from acceptance until flash_csb returns high
- flash_csb  output  1  chip select, active low
- flash_clk  output  1  SPI clock; idles low
- flash_io0  output  1  MOSI
- flash_io1  input  1  MISO

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - flash_csb=1, flash_clk=0, flash_io0=0.
  - rsp_valid=0, rsp_data=0, busy=0.
  - CSB guard counter loaded with CSB_HIGH, so req_ready=0 for the first CSB_HIGH cycles after reset release.
- States: IDLE, SHIFT, RESP.
  - SHIFT covers 64 bits: 8 command bits, 24 address bits, 32 data bits.
- req_ready = (state==IDLE) && !rsp_valid && guard counter==0.
- Acceptance at cycle 0:
  - Shift register loads {0x03, req_addr}.
  - At cycle 1: flash_csb=0, flash_io0=bit 7 of the command, busy=1.
- Half-period counter:
  - Counts 0..CLK_DIV-1; wrap produces a tick.
  - Each tick toggles flash_clk.
- Rising toggle of flash_clk: sample flash_io1 into the receive shift register, MSB-first per byte.
- Falling toggle of flash_clk: drive the next outgoing bit on flash_io0.
  - After bit 32, flash_io0 is driven 0 for the rest of the transfer.
- First rising flash_clk occurs at cycle 1+CLK_DIV. Bit n rises at cycle 1+CLK_DIV+(n-1)·2·CLK_DIV.
- After the 64th rising edge, hold flash_clk high for one half-period, then in the same cycle:
  - flash_clk=0, flash_csb=1, busy=0.
  - rsp_valid=1, rsp_data=assembled word.
  - Enter RESP.
  - This is cycle 1+128·CLK_DIV after acceptance (257 at default).
- Byte assembly: byte k (k=0..3, in received order) lands in rsp_data[8k+7:8k].
- RESP:
  - rsp_valid and rsp_data are held stable until rsp_ready=1.
  - rsp_valid drops on the next edge; rsp_data keeps its value.
  - State returns to IDLE.
- CSB guard:
  - Loads CSB_HIGH when flash_csb rises and decrements every cycle to 0.
  - It runs concurrently with RESP.
  - A new request can therefore be accepted no earlier than max(CSB_HIGH, rsp consumption + 1) cycles after csb rises.
- req_valid while req_ready=0 is ignored and not queued; the requester must hold it.
- req_addr changes after acceptance have no effect.
- Address wrap at 0xFFFFFC..0xFFFFFF is the flash's concern; the controller sends the address unmodified.

Optional Feature:
- Macro: SPI_FLASH_READER_FAST_READ_EN.
- Defined:
  - Command is FAST_READ (0x0B).
  - 8 dummy clocks follow the address: flash_io0=0, flash_io1 samples discarded.
  - Transfer is 72 clocks; rsp_valid rises at cycle 1+144·CLK_DIV (289 at default).
- Undefined: READ (0x03), 64 clocks, timing as in Behaviour.

Test Plan:
- Flash model preloaded with 0x11,0x22,0x33,0x44 at 0x000000; request addr 0x000000, rsp_ready=1 → flash_io0 shows 0x03,0x00,0x00,0x00; rsp_valid at cycle 257; rsp_data=0x44332211; flash_csb high same cycle.
- Bytes 0xEF,0xBE,0xAD,0xDE at 0x123458; request 0x123458 with CLK_DIV=1 → address bits on io0 = 0x123458 MSB-first; rsp_data=0xDEADBEEF at cycle 129.
- Hold rsp_ready=0 for 20 cycles after rsp_valid, req_valid=1 throughout → rsp_data stable; req_ready=0 until the cycle after rsp_ready pulses; second transaction csb falls at least CSB_HIGH cycles after the first csb rise.
- Back-to-back requests with rsp_ready=1, CSB_HIGH=4 → measured csb-high gap ≥4 cycles; flash_clk never toggles while csb is high.
- Assert resetb=0 at cycle 100 of a transfer → flash_csb=1, flash_clk=0, rsp_valid=0, busy=0 immediately (asynchronously); after release, req_ready rises after CSB_HIGH cycles and the next read returns correct data.
- With SPI_FLASH_READER_FAST_READ_EN defined → command byte 0x0B, 8 idle dummy clocks, rsp_valid at cycle 289, data matches the preloaded word.

Source files
------------

// File: rtl/spi_flash_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_flash_reader: mode-0 single-bit SPI flash read initiator. It sends a   |
// | command and a 24-bit address, then returns 4 bytes as one LE 32-bit word.  |
// | Optional: SPI_FLASH_READER_FAST_READ_EN selects FAST_READ with 8 dummies.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_flash_reader #(
  parameter int CLK_DIV  = 2,
  parameter int CSB_HIGH = 4
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

`ifdef SPI_FLASH_READER_FAST_READ_EN
  localparam logic [7:0] CMD        = 8'h0B;
  localparam logic [6:0] TOTAL_BITS = 7'd72;
  localparam logic [6:0] DATA_START = 7'd40;
`else
  localparam logic [7:0] CMD        = 8'h03;
  localparam logic [6:0] TOTAL_BITS = 7'd64;
  localparam logic [6:0] DATA_START = 7'd32;
`endif
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GUARD_INIT = 8'(CSB_HIGH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [6:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d;
  logic        csb_q, csb_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        busy_q, busy_d;
  logic [7:0]  guard_q, guard_d;
  logic        tick;

  assign req_ready = (state_q == S_IDLE) && !rsp_valid_q && (guard_q == 8'd0);
  assign tick      = (div_q == DIV_LAST);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sclk_d      = sclk_q;
    csb_d       = csb_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    guard_d     = (guard_q != 8'd0) ? guard_q - 8'd1 : 8'd0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = S_SHIFT;
          tx_d    = {CMD, req_addr};
          rx_d    = 32'd0;
          csb_d   = 1'b0;
          busy_d  = 1'b1;
          div_d   = 8'd0;
          bit_d   = 7'd0;
        end
      end
      S_SHIFT: begin
        if (!tick) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            bit_d  = bit_q + 7'd1;
            if (bit_q >= DATA_START) rx_d = {rx_q[30:0], flash_io1};
          end else begin
            // tx empties after 32 falls, so io0 naturally idles at 0 afterwards
            sclk_d = 1'b0;
            tx_d   = tx_q << 1;
            if (bit_q == TOTAL_BITS) begin
              csb_d       = 1'b1;
              busy_d      = 1'b0;
              rsp_valid_d = 1'b1;
              rsp_data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
              guard_d     = GUARD_INIT;
              state_d     = S_RESP;
            end
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= S_IDLE;
      div_q       <= 8'd0;
      bit_q       <= 7'd0;
      sclk_q      <= 1'b0;
      csb_q       <= 1'b1;
      tx_q        <= 32'd0;
      rx_q        <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      busy_q      <= 1'b0;
      guard_q     <= GUARD_INIT;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      csb_q       <= csb_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      guard_q     <= guard_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign flash_csb = csb_q;
  assign flash_clk = sclk_q;
  assign flash_io0 = tx_q[31];

endmodule
`default_nettype wire
